// File: rtl/fpu_addsub_ctrl.sv
// Issue/response controller for the binary32 add/sub core: resolves rounding, bypasses special operands, maps core results to fflags.
// Optional FPU_FFLAGS_ACC_EN adds a sticky fflags accumulator (fflags_clr / fflags_acc).
module fpu_addsub_ctrl #(
  parameter int          LAT_MAX   = 15,
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_rm,
  input  logic [2:0]  csr_frm,
  output logic        core_start,
  output logic        core_add0_sub1,
  output logic [31:0] core_operA,
  output logic [31:0] core_operB,
  output logic [2:0]  core_frm,
  input  logic [31:0] core_result,
  input  logic        core_nx,
  input  logic        core_done,
`ifdef FPU_FFLAGS_ACC_EN
  input  logic        fflags_clr,
  output logic [4:0]  fflags_acc,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        busy
);

  localparam int CNT_W = (LAT_MAX < 3) ? 1 : $clog2(LAT_MAX);
  localparam logic [4:0] FLAG_NV = 5'b10000;
  localparam logic [4:0] FLAG_OF_NX = 5'b00101;

  typedef enum logic [2:0] {IDLE, CLASSIFY, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               op_q;
  logic [31:0]        a_q, b_q, res_q;
  logic [2:0]         rm_q;
  logic [4:0]         flags_q;
  logic [CNT_W-1:0]   cnt_q;

  logic        sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic        rm_bad, rdn, timeout;
  logic        byp_hit;
  logic [31:0] byp_res, zero_res;
  logic [4:0]  byp_flags;
  logic        core_sign, to_inf;
  logic [31:0] done_res;
  logic [4:0]  done_flags;

  // Subnormals classify as zero (exponent 0), which flushes them without a flag
  assign sa       = a_q[31];
  assign sb       = b_q[31] ^ op_q;
  assign a_zero   = (a_q[30:23] == 8'h00);
  assign b_zero   = (b_q[30:23] == 8'h00);
  assign a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_snan   = a_nan && !a_q[22];
  assign b_snan   = b_nan && !b_q[22];
  assign rm_bad   = (rm_q == 3'b101) || (rm_q == 3'b110) || (rm_q == 3'b111);
  assign rdn      = (rm_q == 3'b010);
  assign zero_res = {rdn, 31'd0};
  assign timeout  = (cnt_q == CNT_W'(LAT_MAX - 1));

  always_comb begin
    byp_hit   = 1'b1;
    byp_res   = CANON_NAN;
    byp_flags = 5'b00000;
    if (rm_bad) begin
      byp_flags = FLAG_NV;
    end else if (a_snan || b_snan) begin
      byp_flags = FLAG_NV;
    end else if (a_nan || b_nan) begin
      byp_flags = 5'b00000;
    end else if (a_inf && b_inf && (sa != sb)) begin
      byp_flags = FLAG_NV;
    end else if (a_inf) begin
      byp_res = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      byp_res = {sb, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      byp_res = (sa == sb) ? {sa, 31'd0} : zero_res;
    end else if (a_zero) begin
      byp_res = {sb, b_q[30:0]};
    end else if (b_zero) begin
      byp_res = a_q;
    end else if ((a_q[30:0] == b_q[30:0]) && (sa != sb)) begin
      byp_res = zero_res;
    end else begin
      byp_hit = 1'b0;
    end
  end

  // Core overflow saturates to Inf or max-finite depending on rounding direction
  assign core_sign = core_result[31];
  assign to_inf    = (rm_q == 3'b000) || (rm_q == 3'b100) ||
                     ((rm_q == 3'b011) && !core_sign) || ((rm_q == 3'b010) && core_sign);

  always_comb begin
    done_res   = core_result;
    done_flags = {4'b0000, core_nx};
    if (core_result[30:23] == 8'hFF) begin
      done_res   = to_inf ? {core_sign, 8'hFF, 23'd0} : {core_sign, 31'h7F7F_FFFF};
      done_flags = FLAG_OF_NX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = CLASSIFY;
      end
      CLASSIFY: state_d = byp_hit ? RESP : ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: if (core_done || timeout) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rm_q    <= 3'b000;
      res_q   <= 32'd0;
      flags_q <= 5'b00000;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
          rm_q <= (req_rm == 3'b111) ? csr_frm : req_rm;
        end
        CLASSIFY: begin
          cnt_q <= '0;
          if (byp_hit) begin
            res_q   <= byp_res;
            flags_q <= byp_flags;
          end
        end
        WAIT: begin
          if (core_done) begin
            res_q   <= done_res;
            flags_q <= done_flags;
          end else if (timeout) begin
            res_q   <= CANON_NAN;
            flags_q <= FLAG_NV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Latched operands already hold steady from ISSUE through the done cycle
  assign core_add0_sub1 = op_q;
  assign core_operA     = a_q;
  assign core_operB     = b_q;
  assign core_frm       = rm_q;
  assign rsp_result     = res_q;
  assign rsp_flags      = flags_q;

`ifdef FPU_FFLAGS_ACC_EN
  // Clear-then-set: a clear coinciding with a handshake keeps only the new flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_acc <= 5'b00000;
    end else if (rsp_valid && rsp_ready) begin
      fflags_acc <= fflags_clr ? rsp_flags : (fflags_acc | rsp_flags);
    end else if (fflags_clr) begin
      fflags_acc <= 5'b00000;
    end
  end
`endif

endmodule

// File: doc/fpu_addsub_ctrl.md
Name: fpu_addsub_ctrl

Overview:
Issue/response controller that sits directly upstream of the single-precision add/sub core. It accepts add/sub requests over a valid/ready handshake and resolves the dynamic rounding mode. Special operands (NaN, Inf, zero, subnormal, exact cancellation) are handled locally without using the core. All other operands are launched on the core's start/done protocol, and its result and NX flag are post-processed into RISC-V fflags on a valid/ready response port.

Parameters:
LAT_MAX, 15, watchdog limit in cycles spent in WAIT before the operation is aborted.
CANON_NAN, 32'h7FC00000, canonical quiet NaN returned for all NaN/invalid results.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  1  0 = add, 1 = sub
req_a  in  32  operand A (IEEE-754 binary32)
req_b  in  32  operand B (IEEE-754 binary32)
req_rm  in  3  instruction rounding mode; 3'b111 = dynamic
csr_frm  in  3  fcsr.frm, used when req_rm = 3'b111
core_start  out  1  one-cycle launch pulse to the core
core_add0_sub1  out  1  operation to the core
core_operA  out  32  operand A to the core
core_operB  out  32  operand B to the core
core_frm  out  3  resolved rounding mode to the core
core_result  in  32  core result
core_nx  in  1  core inexact flag
core_done  in  1  core completion pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_result  out  32  final result
rsp_flags  out  5  {NV, DZ, OF, UF, NX}
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State = IDLE. All core_* outputs = 0.
- FSM states: IDLE, CLASSIFY, ISSUE, WAIT, RESP.
- IDLE: req_ready = 1. On handshake, latch op, a, b and the resolved rm, then go to CLASSIFY. req_ready = 0 in all other states.
- Rounding-mode resolution: rm = (req_rm == 3'b111) ? csr_frm : req_rm. If the resolved rm is 101, 110 or 111: result CANON_NAN, flags NV, route to RESP.
- CLASSIFY: the effective sign of B is b[31] ^ op. Subnormal inputs are flushed to a same-signed zero (no flag). Priority order:
  1. Either operand is sNaN (exp = FF, frac != 0, frac[22] = 0): CANON_NAN, NV.
  2. Either operand is qNaN: CANON_NAN, no flag.
  3. Both operands Inf with opposite effective signs: CANON_NAN, NV.
  4. One or both operands Inf: that Inf, with its effective sign.
  5. Both operands zero: same signs give that signed zero; different signs give +0, or -0 when rm = RDN.
  6. One operand zero: the other operand, with its effective sign.
  7. Equal magnitudes with opposite effective signs: +0 (-0 when rm = RDN).
  8. Otherwise go to ISSUE.
  All bypass cases (1-7) go to RESP.
- ISSUE: drive core_operA/B/add0_sub1/frm and assert core_start for exactly 1 cycle, then go to WAIT. core_* data outputs stay stable from ISSUE until the core_done cycle.
- WAIT: an up-counter starts at 0. On core_done, capture the result and go to RESP.
  - Core result exponent = FF: OF | NX. The result is ±Inf for RNE/RMM, for RUP when positive and for RDN when negative; otherwise ±7F7FFFFF.
  - Otherwise: NX = core_nx.
  - If the counter reaches LAT_MAX before core_done: CANON_NAN, NV, go to RESP. A late core_done is then ignored.
- RESP: rsp_valid = 1; rsp_result and rsp_flags are held stable. When rsp_ready is high, return to IDLE. There is no back-to-back accept in that cycle; req_ready rises the following cycle.
- Latency from the accept edge to rsp_valid:
  - Bypass path: 2 cycles.
  - Core path: core_done cycle + 1. With the nominal core this is 9 cycles.
- DZ and UF are always 0.
- rst asserted in any state: next cycle the FSM is IDLE, rsp_valid = 0 and core_start = 0. The in-flight operation is discarded, and a core_done arriving after reset is ignored.

Optional Feature:
FPU_FFLAGS_ACC_EN:
- With the macro defined: adds input fflags_clr (1) and output fflags_acc (5). fflags_acc ORs in rsp_flags on each response handshake. When fflags_clr is high in the same cycle as a handshake, the new flags win (clear, then set). rst clears fflags_acc to 0.
- Without the macro: neither port exists and no accumulator logic is built.

Test Plan:
- 3F800000 + 40000000, rm = 000: core_start pulses once -> rsp_result 40400000, flags 00000, rsp_valid at core_done + 1.
- 7F800000 - 7F800000 -> bypass, rsp_result 7FC00000, flags 10000, rsp_valid 2 cycles after accept, core_start never asserted.
- 7F800001 + 3F800000 -> 7FC00000, NV. Then 7FC00001 + 3F800000 -> 7FC00000, flags 00000.
- 40400000 - 40400000, rm = 010 -> 80000000. Same operation with rm = 000 -> 00000000.
- req_rm = 111 with csr_frm = 001 -> core_frm = 001 for the whole launch. req_rm = 101 -> 7FC00000, NV, no core launch.
- Hold rsp_ready low for 4 cycles -> rsp_valid/result stay stable and req_ready stays 0. Separately: assert rst in WAIT, then pulse core_done -> no response produced. Separately: core_done withheld -> 7FC00000, NV after LAT_MAX cycles.
